// File: rtl/ascii_dec_parser_if.sv
// ascii_dec_parser_if
// Bundles the character input stream and the number output stream of the
// ASCII decimal parser.
//   in_valid/in_ready/in_data/in_last : character stream into the parser
//   out_valid/out_ready/out_value/out_eol/out_ovf/out_last : number stream out
//   done : level, whole stream consumed
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid && ready; the sender holds its payload stable while valid is
// high and ready is low, and ready never depends on valid.
// slave  = parser side, master = producer/consumer side.
interface ascii_dec_parser_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_value;
  logic         out_eol;
  logic         out_ovf;
  logic         out_last;
  logic         done;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_value, out_eol, out_ovf, out_last, done
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_value, out_eol, out_ovf, out_last, done
  );
endinterface

// File: rtl/ascii_dec_parser.sv
// ascii_dec_parser
// Turns a stream of ASCII characters into unsigned W-bit integers, one per
// run of decimal digits. Newline (0x0A) and any non-digit end a number; runs
// of terminators with no digits in between emit nothing.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; discards partial and held numbers
//   bus   : ascii_dec_parser_if.slave (character in, number out, done)
module ascii_dec_parser #(
  parameter int W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  ascii_dec_parser_if.slave    bus
);

  logic [W-1:0] acc_q, acc_d;
  logic         ovf_acc_q, ovf_acc_d;
  logic         pending_q, pending_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_value_q, out_value_d;
  logic         out_eol_q, out_eol_d;
  logic         out_ovf_q, out_ovf_d;
  logic         out_last_q, out_last_d;
  logic         done_q, done_d;

  logic         in_ready;
  logic         accept;
  logic         is_digit;
  logic         is_newline;
  logic [3:0]   digit;
  logic [W+3:0] acc_x10;
  logic [W-1:0] acc_next;
  logic         ovf_next;

  // Input is taken whenever the output register is free or being drained.
  assign in_ready   = !reset && (!out_valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready;
  assign is_digit   = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
  assign is_newline = (bus.in_data == 8'h0A);
  // ASCII digits sit at 0x30..0x39, so the low nibble is the digit value.
  assign digit      = bus.in_data[3:0];

  // acc*10 + d without a multiplier; 4 extra bits hold the full result so
  // any spill above W marks overflow.
  assign acc_x10  = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1)
                  + {{W{1'b0}}, digit};
  assign acc_next = acc_x10[W-1:0];
  assign ovf_next = ovf_acc_q || (acc_x10[W+3:W] != 4'b0);

  always_comb begin
    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_eol_d   = out_eol_q;
    out_ovf_d   = out_ovf_q;
    out_last_d  = out_last_q;
    done_d      = done_q;

    // Output drained this cycle; a final number completes the stream.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      if (out_last_q) done_d = 1'b1;
    end

    if (accept) begin
      // Any accepted character starts (or continues) a new stream.
      done_d = 1'b0;
      if (is_digit) begin
        if (bus.in_last) begin
          out_valid_d = 1'b1;
          out_value_d = acc_next;
          out_eol_d   = 1'b0;
          out_ovf_d   = ovf_next;
          out_last_d  = 1'b1;
          acc_d       = '0;
          ovf_acc_d   = 1'b0;
          pending_d   = 1'b0;
        end else begin
          acc_d       = acc_next;
          ovf_acc_d   = ovf_next;
          pending_d   = 1'b1;
        end
      end else if (pending_q) begin
        out_valid_d = 1'b1;
        out_value_d = acc_q;
        out_eol_d   = is_newline;
        out_ovf_d   = ovf_acc_q;
        out_last_d  = bus.in_last;
        acc_d       = '0;
        ovf_acc_d   = 1'b0;
        pending_d   = 1'b0;
      end else if (bus.in_last) begin
        // Stream ends on a terminator with nothing pending: no number left.
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      pending_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_eol_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_eol_q   <= out_eol_d;
      out_ovf_q   <= out_ovf_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
  assign bus.out_eol   = out_eol_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_last  = out_last_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ascii_dec_parser.sv
// tb_ascii_dec_parser
// Drives the same character stream into a W=32 and a W=8 parser (emission
// timing does not depend on W) and scoreboards each output stream against
// hand-chosen decimal values.
module tb_ascii_dec_parser;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic       in_valid  = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic       in_last   = 1'b0;
  logic       out_ready = 1'b1;
  logic       mon_en    = 1'b0;

  ascii_dec_parser_if #(.W(32)) if32 ();
  ascii_dec_parser_if #(.W(8))  if8 ();

  assign if32.in_valid  = in_valid;
  assign if32.in_data   = in_data;
  assign if32.in_last   = in_last;
  assign if32.out_ready = out_ready;
  assign if8.in_valid   = in_valid;
  assign if8.in_data    = in_data;
  assign if8.in_last    = in_last;
  assign if8.out_ready  = out_ready;

  ascii_dec_parser #(.W(32)) u_dut32 (.clock(clock), .reset(reset), .bus(if32));
  ascii_dec_parser #(.W(8))  u_dut8  (.clock(clock), .reset(reset), .bus(if8));

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry: {last, ovf, eol, value[31:0]}
  logic [34:0] exp32_q[$];
  logic [34:0] exp8_q[$];

  task automatic push(input longint unsigned v, input bit eol, input bit last);
    logic [63:0] vv;
    vv = v;
    exp32_q.push_back({last, (vv > 64'hFFFF_FFFF), eol, vv[31:0]});
    exp8_q.push_back({last, (vv > 64'hFF), eol, 24'b0, vv[7:0]});
  endtask

  always @(negedge clock) begin
    logic [34:0] e;
    if (mon_en && if32.out_valid === 1'b1 && out_ready) begin
      if (exp32_q.size() == 0) chk("out32_extra", exp32_q.size(), 1);
      else begin
        e = exp32_q.pop_front();
        chk("out32", {29'b0, if32.out_last, if32.out_ovf, if32.out_eol, if32.out_value},
            {29'b0, e});
      end
    end
    if (mon_en && if8.out_valid === 1'b1 && out_ready) begin
      if (exp8_q.size() == 0) chk("out8_extra", exp8_q.size(), 1);
      else begin
        e = exp8_q.pop_front();
        chk("out8", {29'b0, if8.out_last, if8.out_ovf, if8.out_eol, 24'b0, if8.out_value},
            {29'b0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; returns at posedge+#1 right after the accept edge.
  task automatic send_char(input byte c, input bit last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = c;
    in_last  = last;
    @(negedge clock);
    while (!if32.in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!if32.in_ready) chk("accept_timeout", if32.in_ready, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_final);
    for (int i = 0; i < s.len(); i++)
      send_char(s[i], last_final && (i == s.len() - 1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Holds reset for n cycles and checks every output is cleared meanwhile.
  task automatic do_reset(input int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(posedge clock);
    #1;
    chk("rst_in_ready", {if8.in_ready, if32.in_ready}, 0);
    chk("rst_out32", {if32.out_valid, if32.out_eol, if32.out_ovf, if32.out_last,
                      if32.done, if32.out_value}, 0);
    chk("rst_out8", {if8.out_valid, if8.out_eol, if8.out_ovf, if8.out_last,
                     if8.done, if8.out_value}, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int unsigned t0;
    do_reset(3);
    chk("in_ready_after_rst", if32.in_ready, 1);
    mon_en = 1'b1;

    // "123\n": one output, one cycle after the newline, lasting one cycle.
    push(123, 1, 0);
    send_str("123\n", 0);
    chk("lat_valid", {if32.out_valid, if32.out_value}, {1'b1, 32'd123});
    idle(1);
    chk("one_cycle_valid", if32.out_valid, 0);

    // Separators, blank line, double space.
    push(7, 0, 0);
    push(42, 0, 0);
    push(9, 0, 0);
    send_str("7,42  \n\n9 ", 0);
    idle(2);

    // Overflow on W=8 (300 -> 44), sticky flag cleared for the next number.
    push(300, 0, 0);
    push(12, 0, 0);
    send_str("300,12,", 0);
    // W=32 boundary: 2^32-1 fits, 2^32 wraps to 0 with ovf.
    push(64'd4294967295, 0, 0);
    push(64'd4294967296, 1, 0);
    send_str("4294967295 4294967296\n", 0);
    // Leading zeros, CR as separator.
    push(7, 0, 0);
    send_str("007\r", 0);
    idle(2);

    // Full throughput with back-to-back terminators: 7 chars in 7 cycles.
    push(1, 0, 0);
    push(2, 0, 0);
    push(3, 1, 0);
    t0 = cyc;
    send_str("1,2,\n3\n", 0);
    chk("throughput_cycles", cyc - t0, 7);
    idle(2);

    // Final digit with in_last: emitted immediately, done after handshake.
    push(5, 0, 1);
    send_str("5", 1);
    chk("last_out_valid", {if32.out_valid, if32.out_last, if32.done}, 3'b110);
    idle(1);
    chk("done_set", {if32.done, if32.out_valid, if8.done}, 3'b101);
    idle(3);
    chk("done_level", if32.done, 1);
    send_char(" ", 0);
    chk("done_cleared", {if32.done, if8.done}, 0);

    // Terminator with in_last and nothing pending: done, no emission.
    send_char("\n", 1);
    chk("done_sep_last", {if32.done, if32.out_valid}, 2'b10);
    idle(2);

    // Backpressure: first number held while further input is refused.
    push(1, 0, 0);
    push(2, 0, 0);
    push(3, 0, 0);
    out_ready = 1'b0;
    fork
      send_str("1 2 3 ", 0);
      begin
        int n;
        n = 0;
        while (!if32.out_valid && n < 20) begin
          @(negedge clock);
          n++;
        end
        chk("bp_valid", if32.out_valid, 1);
        for (int i = 0; i < 10; i++) begin
          @(negedge clock);
          chk("bp_hold32", {if32.in_ready, if32.out_valid, if32.out_value}, {2'b01, 32'd1});
          chk("bp_hold8", {if8.in_ready, if8.out_valid, if8.out_value}, {2'b01, 8'd1});
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(3);

    // Reset mid-number: "98" discarded, only 4 emitted afterwards.
    send_str("98", 0);
    do_reset(2);
    push(4, 0, 0);
    send_str("4 ", 0);
    idle(3);

    // Reset with an output held: the held number must vanish.
    out_ready = 1'b0;
    send_str("6 ", 0);
    idle(2);
    chk("held_before_rst", {if32.out_valid, if32.out_value}, {1'b1, 32'd6});
    mon_en = 1'b0;
    do_reset(2);
    out_ready = 1'b1;
    mon_en = 1'b1;
    push(8, 1, 0);
    send_str("8\n", 0);
    idle(4);

    chk("q32_drained", exp32_q.size(), 0);
    chk("q8_drained", exp8_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute safety net against a hung run.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
